// File: rtl/my9262_pkg.sv
// Shared types and constants for the MY9262 serial shift controller.
// Optional feature macro: MY9262_DONE_IRQ_EN (see my9262_shift_ctrl).
package my9262_pkg;

    localparam int WORD_W         = 16;
    localparam int BCNT_W         = 4;
    localparam int WCNT_W         = 4;
    localparam int MY9262_STATE_W = 3;

    typedef enum logic [MY9262_STATE_W-1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        WORD_END,
        LATCH
    } state_t;

    // Counter wide enough to hold the larger of the two reload values
    function automatic int tick_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/my9262_tick_gen.sv
// Reloadable down-counter: o_tick is high in the i_load'th cycle after
// i_restart; holds at zero until the next restart.
module my9262_tick_gen #(
    parameter int CNT_W = 3
) (
    input  logic             csi_clk,
    input  logic             rsi_reset,
    input  logic             i_restart,
    input  logic [CNT_W-1:0] i_load,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= i_load - CNT_W'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/my9262_shift_ctrl.sv
// Serialises 16-bit words onto MY9262 DCK/DI/LAT, latching every NUM_DEV words.
// Define MY9262_DONE_IRQ_EN to add a sticky irq output set by frame_done.
module my9262_shift_ctrl
    import my9262_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int NUM_DEV    = 1,
    parameter int LAT_CYCLES = 4
) (
    input  logic              csi_clk,
    input  logic              rsi_reset,
    input  logic [WORD_W-1:0] my9262_Data,
    input  logic              my9262_Start,
    input  logic              overrun_clr,
    output logic              my9262_DCK,
    output logic              my9262_DI,
    output logic              my9262_LAT,
    output logic              busy,
    output logic              frame_done,
`ifdef MY9262_DONE_IRQ_EN
    output logic              overrun,
    output logic              irq
`else
    output logic              overrun
`endif
);

    localparam int DIV_W = tick_cnt_w(CLK_DIV, LAT_CYCLES);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_DEV - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_sreg;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic                r_frame_done;
    logic                r_overrun;
    logic                w_tick;
    logic                w_restart;
    logic [DIV_W-1:0]    w_load;
    logic                w_load_word;
    logic                w_bit_done;
    logic                w_lat_done;
    logic                w_busy;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (my9262_Start) w_state_nxt = SHIFT_LO;
            SHIFT_LO: if (w_tick) w_state_nxt = SHIFT_HI;
            SHIFT_HI: begin
                if (w_tick) begin
                    w_state_nxt = (r_bit_cnt == '0) ? WORD_END : SHIFT_LO;
                end
            end
            WORD_END: begin
                w_state_nxt = (r_word_cnt == LAST_WORD) ? LATCH : IDLE;
            end
            LATCH:    if (w_tick) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Divider restarts on every state change so DCK edges track the FSM
    assign w_restart = (w_state_nxt != r_state);
    assign w_load    = (w_state_nxt == LATCH) ? DIV_W'(LAT_CYCLES)
                                              : DIV_W'(CLK_DIV);

    my9262_tick_gen #(
        .CNT_W (DIV_W)
    ) u_tick (
        .csi_clk   (csi_clk),
        .rsi_reset (rsi_reset),
        .i_restart (w_restart),
        .i_load    (w_load),
        .o_tick    (w_tick)
    );

    assign w_busy      = (r_state != IDLE);
    assign w_load_word = (r_state == IDLE) && my9262_Start;
    assign w_bit_done  = (r_state == SHIFT_HI) && w_tick;
    assign w_lat_done  = (r_state == LATCH) && w_tick;

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            r_state      <= IDLE;
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_lat_done;
            if (w_load_word) begin
                r_sreg    <= my9262_Data;
                r_bit_cnt <= BCNT_W'(WORD_W - 1);
            end else if (w_bit_done) begin
                r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
                if (r_bit_cnt != '0) begin
                    r_bit_cnt <= r_bit_cnt - BCNT_W'(1);
                end
            end
            if (r_state == WORD_END) begin
                r_word_cnt <= (r_word_cnt == LAST_WORD)
                            ? '0 : r_word_cnt + WCNT_W'(1);
            end
        end
    end

    // A Start that hits a busy engine is lost; set beats clear
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            r_overrun <= 1'b0;
        end else if (my9262_Start && w_busy) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef MY9262_DONE_IRQ_EN
    logic r_irq;

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            r_irq <= 1'b0;
        end else if (w_lat_done) begin
            r_irq <= 1'b1;
        end else if (overrun_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

    assign my9262_DCK = (r_state == SHIFT_HI);
    assign my9262_DI  = ((r_state == SHIFT_LO) || (r_state == SHIFT_HI))
                      && r_sreg[WORD_W-1];
    assign my9262_LAT = (r_state == LATCH);
    assign busy       = w_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_my9262_shift_ctrl.sv
// Randomised self-checking bench for my9262_shift_ctrl (two configurations).
// Define MY9262_DONE_IRQ_EN to also exercise the irq output.
module tb_my9262_shift_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] data_a, data_b;
    logic        start_a, start_b, clr_a, clr_b;
    logic        dck_a, di_a, lat_a, busy_a, fd_a, ov_a;
    logic        dck_b, di_b, lat_b, busy_b, fd_b, ov_b;
`ifdef MY9262_DONE_IRQ_EN
    logic        irq_a, irq_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    my9262_shift_ctrl #(
        .CLK_DIV(2), .NUM_DEV(2), .LAT_CYCLES(4)
    ) dut_a (
        .csi_clk      (clk),
        .rsi_reset    (rst),
        .my9262_Data  (data_a),
        .my9262_Start (start_a),
        .overrun_clr  (clr_a),
        .my9262_DCK   (dck_a),
        .my9262_DI    (di_a),
        .my9262_LAT   (lat_a),
        .busy         (busy_a),
        .frame_done   (fd_a),
`ifdef MY9262_DONE_IRQ_EN
        .overrun      (ov_a),
        .irq          (irq_a)
`else
        .overrun      (ov_a)
`endif
    );

    my9262_shift_ctrl #(
        .CLK_DIV(1), .NUM_DEV(1), .LAT_CYCLES(4)
    ) dut_b (
        .csi_clk      (clk),
        .rsi_reset    (rst),
        .my9262_Data  (data_b),
        .my9262_Start (start_b),
        .overrun_clr  (clr_b),
        .my9262_DCK   (dck_b),
        .my9262_DI    (di_b),
        .my9262_LAT   (lat_b),
        .busy         (busy_b),
        .frame_done   (fd_b),
`ifdef MY9262_DONE_IRQ_EN
        .overrun      (ov_b),
        .irq          (irq_b)
`else
        .overrun      (ov_b)
`endif
    );

    // Wire-level observers: what a downstream MY9262 chain would see
    int   rises_a = 0, lat_p_a = 0, lat_cyc_a = 0, fd_cnt_a = 0;
    int   fd_ok_a = 0, busy_cyc_a = 0, rises_at_lat_a = 0;
    logic p_dck_a = 1'b0, p_lat_a = 1'b0;
    logic bits_a[$];

    int   rises_b = 0, lat_p_b = 0, lat_cyc_b = 0, fd_cnt_b = 0;
    int   busy_cyc_b = 0, rises_at_lat_b = 0, di_hi_b = 0;
    logic p_dck_b = 1'b0, p_lat_b = 1'b0;
    logic bits_b[$];

    always @(negedge clk) begin
        if (dck_a && !p_dck_a) begin
            rises_a = rises_a + 1;
            bits_a.push_back(di_a);
        end
        if (lat_a && !p_lat_a) begin
            lat_p_a = lat_p_a + 1;
            rises_at_lat_a = rises_a;
        end
        if (lat_a) lat_cyc_a = lat_cyc_a + 1;
        if (fd_a) begin
            fd_cnt_a = fd_cnt_a + 1;
            if (p_lat_a && !lat_a) fd_ok_a = fd_ok_a + 1;
        end
        if (busy_a) busy_cyc_a = busy_cyc_a + 1;
        p_dck_a = dck_a;
        p_lat_a = lat_a;
    end

    always @(negedge clk) begin
        if (dck_b && !p_dck_b) begin
            rises_b = rises_b + 1;
            bits_b.push_back(di_b);
        end
        if (lat_b && !p_lat_b) begin
            lat_p_b = lat_p_b + 1;
            rises_at_lat_b = rises_b;
        end
        if (lat_b) lat_cyc_b = lat_cyc_b + 1;
        if (fd_b) fd_cnt_b = fd_cnt_b + 1;
        if (busy_b) busy_cyc_b = busy_cyc_b + 1;
        if (di_b) di_hi_b = di_hi_b + 1;
        p_dck_b = dck_b;
        p_lat_b = lat_b;
    end

    function automatic logic [31:0] grab_a(input int base, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (base + i < bits_a.size()) v = {v[30:0], bits_a[base+i]};
            else v = {v[30:0], 1'bx};
        end
        return v;
    endfunction

    function automatic logic [15:0] grab_b(input int base);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            if (base + i < bits_b.size()) v = {v[14:0], bits_b[base+i]};
            else v = {v[14:0], 1'bx};
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        clr_a = 1'b0;   clr_b = 1'b0;
        data_a = 16'h0; data_b = 16'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_a(input logic [15:0] w);
        start_a = 1'b1;
        data_a = w;
        tick();
        start_a = 1'b0;
        data_a = 16'($urandom);
    endtask

    task automatic wait_idle_a(input string tag);
        int k;
        k = 0;
        while (busy_a && k < 300) begin
            tick();
            k++;
        end
        if (busy_a) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout busy=%0b want 0", tag, busy_a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b1; start_b = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        data_a = 16'hFFFF; data_b = 16'hFFFF;
        repeat (2) tick();
        n_vec++;
        if ({dck_a, di_a, lat_a, busy_a, fd_a, ov_a} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_a outs=%b want 000000",
                     {dck_a, di_a, lat_a, busy_a, fd_a, ov_a});
        end
        n_vec++;
        if ({dck_b, di_b, lat_b, busy_b, fd_b, ov_b} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_b outs=%b want 000000",
                     {dck_b, di_b, lat_b, busy_b, fd_b, ov_b});
        end
        do_reset();
    endtask

    task automatic test_single_word();
        int r0, q0, b0, l0;
        do_reset();
        r0 = rises_a; q0 = bits_a.size(); b0 = busy_cyc_a; l0 = lat_p_a;
        send_a(16'hA5C3);
        n_vec++;
        if (di_a !== 1'b1 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL first_di di=%b busy=%b want 1 1", di_a, busy_a);
        end
        repeat (80) tick();
        n_vec++;
        if (rises_a - r0 != 16) begin
            n_err++;
            $display("FAIL single_rises got %0d want 16", rises_a - r0);
        end
        n_vec++;
        if (grab_a(q0, 16) !== 32'h0000A5C3) begin
            n_err++;
            $display("FAIL single_bits got %h want a5c3", grab_a(q0, 16));
        end
        n_vec++;
        if (lat_p_a != l0) begin
            n_err++;
            $display("FAIL single_nolat got %0d want 0", lat_p_a - l0);
        end
        n_vec++;
        if (busy_cyc_a - b0 != 65) begin
            n_err++;
            $display("FAIL single_busy got %0d want 65", busy_cyc_a - b0);
        end
    endtask

    task automatic test_frame(input logic [15:0] w1, input logic [15:0] w2,
                              input int gap, input string tag);
        int r0, q0, l0, lc0, f0, fo0;
        r0 = rises_a; q0 = bits_a.size(); l0 = lat_p_a;
        lc0 = lat_cyc_a; f0 = fd_cnt_a; fo0 = fd_ok_a;
        repeat (gap) tick();
        send_a(w1);
        wait_idle_a(tag);
        repeat (gap) tick();
        send_a(w2);
        wait_idle_a(tag);
        repeat (4) tick();
        n_vec++;
        if (rises_a - r0 != 32 || grab_a(q0, 32) !== {w1, w2}) begin
            n_err++;
            $display("FAIL %s_bits got %0d:%h want 32:%h",
                     tag, rises_a - r0, grab_a(q0, 32), {w1, w2});
        end
        n_vec++;
        if (lat_p_a - l0 != 1 || lat_cyc_a - lc0 != 4) begin
            n_err++;
            $display("FAIL %s_lat pulses=%0d cycles=%0d want 1 4",
                     tag, lat_p_a - l0, lat_cyc_a - lc0);
        end
        n_vec++;
        if (rises_at_lat_a - r0 != 32) begin
            n_err++;
            $display("FAIL %s_lat_pos got %0d want 32",
                     tag, rises_at_lat_a - r0);
        end
        n_vec++;
        if (fd_cnt_a - f0 != 1 || fd_ok_a - fo0 != 1) begin
            n_err++;
            $display("FAIL %s_done cnt=%0d aligned=%0d want 1 1",
                     tag, fd_cnt_a - f0, fd_ok_a - fo0);
        end
        n_vec++;
        if (ov_a !== 1'b0) begin
            n_err++;
            $display("FAIL %s_ov got %b want 0", tag, ov_a);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] w1, w2;
        int r0, q0, l0;
        do_reset();
        w1 = 16'($urandom);
        w2 = ~w1;
        r0 = rises_a; q0 = bits_a.size(); l0 = lat_p_a;
        send_a(w1);
        repeat (9) tick();
        send_a(w2);
        n_vec++;
        if (ov_a !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_set got %b want 1", ov_a);
        end
        start_a = 1'b1; clr_a = 1'b1;
        tick();
        start_a = 1'b0; clr_a = 1'b0;
        n_vec++;
        if (ov_a !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_setwins got %b want 1", ov_a);
        end
        wait_idle_a("ovr");
        repeat (4) tick();
        n_vec++;
        if (rises_a - r0 != 16 || grab_a(q0, 16) !== {16'h0, w1}) begin
            n_err++;
            $display("FAIL ovr_stream got %0d:%h want 16:%h",
                     rises_a - r0, grab_a(q0, 16), w1);
        end
        n_vec++;
        if (lat_p_a != l0) begin
            n_err++;
            $display("FAIL ovr_nolat got %0d want 0", lat_p_a - l0);
        end
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        n_vec++;
        if (ov_a !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clr got %b want 0", ov_a);
        end
    endtask

    task automatic test_reset_mid();
        int l0, r1, k;
        do_reset();
        l0 = lat_p_a;
        send_a(16'($urandom));
        wait_idle_a("rmid");
        r1 = rises_a;
        send_a(16'($urandom));
        k = 0;
        while (rises_a - r1 < 8 && k < 300) begin
            tick();
            k++;
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({dck_a, di_a, lat_a, busy_a, fd_a, ov_a} !== 6'b0) begin
            n_err++;
            $display("FAIL rmid_outs got %b want 000000",
                     {dck_a, di_a, lat_a, busy_a, fd_a, ov_a});
        end
        tick();
        rst = 1'b0;
        tick();
        test_frame(16'($urandom), 16'($urandom), 0, "rmid");
        n_vec++;
        if (lat_p_a - l0 != 1) begin
            n_err++;
            $display("FAIL rmid_onelat got %0d want 1", lat_p_a - l0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            test_frame(16'($urandom), 16'($urandom),
                       int'($urandom_range(0, 3)), "rand");
        end
    endtask

    task automatic test_min_cfg();
        int r0, q0, l0, lc0, f0, b0, d0, k;
        logic [15:0] w;
        do_reset();
        w = 16'h8000;
        r0 = rises_b; q0 = bits_b.size(); l0 = lat_p_b;
        lc0 = lat_cyc_b; f0 = fd_cnt_b; b0 = busy_cyc_b; d0 = di_hi_b;
        start_b = 1'b1; data_b = w;
        tick();
        start_b = 1'b0; data_b = 16'hFFFF;
        k = 0;
        while (busy_b && k < 200) begin
            tick();
            k++;
        end
        repeat (4) tick();
        n_vec++;
        if (rises_b - r0 != 16 || grab_b(q0) !== w) begin
            n_err++;
            $display("FAIL min_bits got %0d:%h want 16:%h",
                     rises_b - r0, grab_b(q0), w);
        end
        n_vec++;
        if (di_hi_b - d0 != $countones(w) * 2) begin
            n_err++;
            $display("FAIL min_di_hi got %0d want %0d",
                     di_hi_b - d0, $countones(w) * 2);
        end
        n_vec++;
        if (lat_p_b - l0 != 1 || rises_at_lat_b - r0 != 16 ||
            lat_cyc_b - lc0 != 4) begin
            n_err++;
            $display("FAIL min_lat p=%0d at=%0d cyc=%0d want 1 16 4",
                     lat_p_b - l0, rises_at_lat_b - r0, lat_cyc_b - lc0);
        end
        n_vec++;
        if (busy_cyc_b - b0 != 37 || fd_cnt_b - f0 != 1) begin
            n_err++;
            $display("FAIL min_time busy=%0d fd=%0d want 37 1",
                     busy_cyc_b - b0, fd_cnt_b - f0);
        end
    endtask

`ifdef MY9262_DONE_IRQ_EN
    task automatic test_irq();
        do_reset();
        n_vec++;
        if (irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL irq_reset got %b want 0", irq_a);
        end
        test_frame(16'hFFFF, 16'h0001, 0, "irq");
        repeat (5) tick();
        n_vec++;
        if (irq_a !== 1'b1) begin
            n_err++;
            $display("FAIL irq_held got %b want 1", irq_a);
        end
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        n_vec++;
        if (irq_a !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clr got %b want 0", irq_a);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        clr_a = 1'b0;   clr_b = 1'b0;
        data_a = 16'h0; data_b = 16'h0;
        test_reset();
        test_single_word();
        do_reset();
        test_frame(16'hFFFF, 16'h0001, 0, "frame");
        test_overrun();
        test_reset_mid();
        test_random();
        test_min_cfg();
`ifdef MY9262_DONE_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
